// File: rtl/elevator_call_latch.sv
// elevator_call_latch
// Request front end for the elevator controller: synchronises and debounces
// the raw floor and door buttons, latches floor calls until the car serves
// them, and picks the next floor to visit in SCAN (sweep) order.
module elevator_call_latch #(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] btn,
  input  logic       btn_open,
  input  logic       btn_close,
  input  logic [2:0] cur_floor,
  input  logic       at_floor,
  input  logic       door_open,
  output logic [7:0] req,
  output logic       req_open,
  output logic       req_close,
  output logic [2:0] target,
  output logic       target_valid,
  output logic [3:0] pending_cnt
);

  localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

  // bits 7:0 floors, bit 8 door-open, bit 9 door-close
  logic [9:0] raw;
  logic [9:0] sync1;
  logic [9:0] sync2;
  logic [9:0] db;
  logic [3:0] db_cnt [10];
  logic [7:0] db_prev;

  logic [7:0] served;
  logic [7:0] press_rise;
  logic [7:0] req_next;
  logic [3:0] cnt_next;

  logic       sweep_up;
  logic       up_found;
  logic [2:0] up_floor;
  logic       dn_found;
  logic [2:0] dn_floor;

  assign raw = {btn_close, btn_open, btn};

  // two-flop synchroniser for every raw button
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // debounce: flip the level after DB_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db <= '0;
      for (int i = 0; i < 10; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= ~db[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 4'd1;
        end
      end
    end
  end

  // serve detection, press edges and next pending set with clear winning
  always_comb begin
    served = '0;
    for (int i = 0; i < 8; i++)
      served[i] = at_floor & door_open & (cur_floor == 3'(i));
    press_rise = db[7:0] & ~db_prev;
    req_next   = (req | press_rise) & ~served;
  end

  // population count of the next pending set
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < 8; i++)
      cnt_next = cnt_next + 4'(req_next[i]);
  end

  // pending calls, count, door requests and edge-detect history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req         <= '0;
      pending_cnt <= '0;
      db_prev     <= '0;
      req_open    <= 1'b0;
      req_close   <= 1'b0;
    end else begin
      req         <= req_next;
      pending_cnt <= cnt_next;
      db_prev     <= db[7:0];
      req_open    <= db[8];
      req_close   <= db[9] & ~db[8];
    end
  end

  // nearest pending floor above and below the car
  always_comb begin
    up_found = 1'b0;
    up_floor = '0;
    dn_found = 1'b0;
    dn_floor = '0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i] && (3'(i) > cur_floor)) begin
        up_found = 1'b1;
        up_floor = 3'(i);
      end
    end
    for (int i = 0; i < 8; i++) begin
      if (req[i] && (3'(i) < cur_floor)) begin
        dn_found = 1'b1;
        dn_floor = 3'(i);
      end
    end
  end

  // SCAN target: current floor, then sweep direction, then reverse sweep
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target       <= '0;
      target_valid <= 1'b0;
      sweep_up     <= 1'b1;
    end else begin
      target_valid <= |req;
      if (req[cur_floor]) begin
        target <= cur_floor;
      end else if (sweep_up && up_found) begin
        target <= up_floor;
      end else if (!sweep_up && dn_found) begin
        target <= dn_floor;
      end else if (sweep_up && dn_found) begin
        target   <= dn_floor;
        sweep_up <= 1'b0;
      end else if (!sweep_up && up_found) begin
        target   <= up_floor;
        sweep_up <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_elevator_call_latch.sv
// tb_elevator_call_latch
// Directed bench for elevator_call_latch with DB_CYCLES = 4.
module tb_elevator_call_latch;

  logic       clk;
  logic       rst;
  logic [7:0] btn;
  logic       btn_open;
  logic       btn_close;
  logic [2:0] cur_floor;
  logic       at_floor;
  logic       door_open;
  logic [7:0] req;
  logic       req_open;
  logic       req_close;
  logic [2:0] target;
  logic       target_valid;
  logic [3:0] pending_cnt;

  int checks = 0;
  int fails  = 0;

  elevator_call_latch #(.DB_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .btn_open     (btn_open),
    .btn_close    (btn_close),
    .cur_floor    (cur_floor),
    .at_floor     (at_floor),
    .door_open    (door_open),
    .req          (req),
    .req_open     (req_open),
    .req_close    (req_close),
    .target       (target),
    .target_valid (target_valid),
    .pending_cnt  (pending_cnt)
  );

  // free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // hard stop in case the sequence ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog expired");
  end

  // advance n rising edges and settle 1 ns past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; btn = '0; btn_open = 0; btn_close = 0;
    cur_floor = 0; at_floor = 0; door_open = 0;
    step(2);
    checks++; if ({req, req_open, req_close} !== 10'h000) begin fails++;
      $display("[TB] FAIL reset_req: got %h/%b/%b, expected 00/0/0", req, req_open, req_close); end
    checks++; if ({target, target_valid, pending_cnt} !== 8'h00) begin fails++;
      $display("[TB] FAIL reset_target: got t=%0d v=%b cnt=%0d, expected 0/0/0", target, target_valid, pending_cnt); end
    rst = 1'b1;
    step(5);
    checks++; if ({req, target_valid, pending_cnt} !== 13'h0) begin fails++;
      $display("[TB] FAIL idle_outputs: got req=%h v=%b cnt=%0d, expected 00/0/0", req, target_valid, pending_cnt); end
    checks++; if (dut.sweep_up !== 1'b1) begin fails++;
      $display("[TB] FAIL reset_sweep: got %b, expected 1", dut.sweep_up); end
  endtask

  task automatic test_single_call();
    cur_floor = 0; at_floor = 0; door_open = 0;
    btn = 8'h08;
    step(6);
    checks++; if (req !== 8'h00) begin fails++;
      $display("[TB] FAIL single_early: got req=%h, expected 00", req); end
    step(1);
    checks++; if (req !== 8'h08 || pending_cnt !== 4'd1) begin fails++;
      $display("[TB] FAIL single_req: got req=%h cnt=%0d, expected 08/1", req, pending_cnt); end
    checks++; if (target_valid !== 1'b0) begin fails++;
      $display("[TB] FAIL single_valid_early: got %b, expected 0", target_valid); end
    step(1);
    checks++; if (target !== 3'd3 || target_valid !== 1'b1) begin fails++;
      $display("[TB] FAIL single_target: got t=%0d v=%b, expected 3/1", target, target_valid); end
    step(2);
    btn = 8'h00;
    step(8);
    checks++; if (req !== 8'h08) begin fails++;
      $display("[TB] FAIL single_release_holds: got req=%h, expected 08", req); end
    cur_floor = 3; at_floor = 1; door_open = 1;
    step(1);
    checks++; if (req !== 8'h00 || pending_cnt !== 4'd0 || target_valid !== 1'b1) begin fails++;
      $display("[TB] FAIL single_clear: got req=%h cnt=%0d v=%b, expected 00/0/1", req, pending_cnt, target_valid); end
    step(1);
    checks++; if (target_valid !== 1'b0) begin fails++;
      $display("[TB] FAIL single_valid_fall: got %b, expected 0", target_valid); end
    at_floor = 0; door_open = 0;
    step(1);
  endtask

  task automatic test_glitch();
    btn = 8'h20;
    step(3);
    btn = 8'h00;
    step(12);
    checks++; if (req !== 8'h00 || pending_cnt !== 4'd0) begin fails++;
      $display("[TB] FAIL glitch: got req=%h cnt=%0d, expected 00/0", req, pending_cnt); end
  endtask

  task automatic test_scan_order();
    cur_floor = 4; at_floor = 0; door_open = 0;
    btn = 8'hC4;
    step(7);
    checks++; if (req !== 8'hC4 || pending_cnt !== 4'd3) begin fails++;
      $display("[TB] FAIL scan_multi_set: got req=%h cnt=%0d, expected c4/3", req, pending_cnt); end
    step(1);
    checks++; if (target !== 3'd6 || target_valid !== 1'b1) begin fails++;
      $display("[TB] FAIL scan_first: got t=%0d v=%b, expected 6/1", target, target_valid); end
    btn = 8'h00;
    step(8);
    cur_floor = 6; at_floor = 1; door_open = 1;
    step(1);
    at_floor = 0; door_open = 0;
    step(2);
    checks++; if (req !== 8'h84 || target !== 3'd7) begin fails++;
      $display("[TB] FAIL scan_second: got req=%h t=%0d, expected 84/7", req, target); end
    cur_floor = 7; at_floor = 1; door_open = 1;
    step(1);
    at_floor = 0; door_open = 0;
    step(2);
    checks++; if (req !== 8'h04 || target !== 3'd2) begin fails++;
      $display("[TB] FAIL scan_reverse: got req=%h t=%0d, expected 04/2", req, target); end
    checks++; if (dut.sweep_up !== 1'b0) begin fails++;
      $display("[TB] FAIL scan_sweep_flag: got %b, expected 0", dut.sweep_up); end
    cur_floor = 2; at_floor = 1; door_open = 1;
    step(1);
    at_floor = 0; door_open = 0;
    step(2);
    checks++; if (req !== 8'h00 || target_valid !== 1'b0) begin fails++;
      $display("[TB] FAIL scan_drain: got req=%h v=%b, expected 00/0", req, target_valid); end
  endtask

  task automatic test_served_press();
    cur_floor = 1; at_floor = 1; door_open = 1;
    btn = 8'h02;
    step(7);
    checks++; if (req !== 8'h00) begin fails++;
      $display("[TB] FAIL served_block_edge: got req=%h, expected 00", req); end
    step(4);
    checks++; if (req !== 8'h00) begin fails++;
      $display("[TB] FAIL served_block_hold: got req=%h, expected 00", req); end
    btn = 8'h00;
    step(10);
    door_open = 0;
    btn = 8'h02;
    step(7);
    checks++; if (req !== 8'h02 || pending_cnt !== 4'd1) begin fails++;
      $display("[TB] FAIL served_door_closed: got req=%h cnt=%0d, expected 02/1", req, pending_cnt); end
    step(1);
    checks++; if (target !== 3'd1 || target_valid !== 1'b1) begin fails++;
      $display("[TB] FAIL served_target: got t=%0d v=%b, expected 1/1", target, target_valid); end
    btn = 8'h00;
    step(10);
    door_open = 1;
    step(1);
    at_floor = 0; door_open = 0;
    step(2);
  endtask

  task automatic test_door_and_reset();
    btn_open = 1; btn_close = 1;
    step(6);
    checks++; if (req_open !== 1'b0) begin fails++;
      $display("[TB] FAIL door_open_early: got %b, expected 0", req_open); end
    step(1);
    checks++; if (req_open !== 1'b1 || req_close !== 1'b0) begin fails++;
      $display("[TB] FAIL door_priority: got open=%b close=%b, expected 1/0", req_open, req_close); end
    btn_open = 0;
    step(6);
    checks++; if (req_open !== 1'b1 || req_close !== 1'b0) begin fails++;
      $display("[TB] FAIL door_release_early: got open=%b close=%b, expected 1/0", req_open, req_close); end
    step(1);
    checks++; if (req_open !== 1'b0 || req_close !== 1'b1) begin fails++;
      $display("[TB] FAIL door_close_after_release: got open=%b close=%b, expected 0/1", req_open, req_close); end
    btn_close = 0;
    step(10);
    cur_floor = 0; at_floor = 0; door_open = 0;
    btn = 8'h38;
    step(7);
    checks++; if (req !== 8'h38 || pending_cnt !== 4'd3) begin fails++;
      $display("[TB] FAIL three_calls: got req=%h cnt=%0d, expected 38/3", req, pending_cnt); end
    btn = 8'h00;
    step(2);
    rst = 1'b0;
    #1;
    checks++; if (req !== 8'h00 || pending_cnt !== 4'd0 || target_valid !== 1'b0) begin fails++;
      $display("[TB] FAIL async_reset: got req=%h cnt=%0d v=%b, expected 00/0/0", req, pending_cnt, target_valid); end
    step(2);
    rst = 1'b1;
    step(3);
    checks++; if (req !== 8'h00 || target !== 3'd0) begin fails++;
      $display("[TB] FAIL post_reset: got req=%h t=%0d, expected 00/0", req, target); end
  endtask

  // run all scenarios in order and report
  initial begin
    test_reset();
    test_single_call();
    test_glitch();
    test_scan_order();
    test_served_press();
    test_door_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/elevator_call_latch.md
# elevator_call_latch

Upstream request stage for the `elevator` controller. Synchronises and debounces the raw car/hall buttons for floors G..7 and the door-open/close buttons, and holds each floor call as a pending level until the car serves it. Its outputs drive `inG`..`in7`, `inopen` and `inclose` directly. It also produces a SCAN-ordered next-target floor for the motion logic.

## Interface
- `DB_CYCLES`, 4, debounce length in cycles; legal 1..15 (4-bit counters).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `btn`  in  8  raw floor buttons, asynchronous; bit 0 = ground, bit 7 = floor 7.
- `btn_open`  in  1  raw door-open button, asynchronous.
- `btn_close`  in  1  raw door-close button, asynchronous.
- `cur_floor`  in  3  current car floor, synchronous to `clk`.
- `at_floor`  in  1  car stopped and aligned at `cur_floor`.
- `door_open`  in  1  `open` output of `elevator`.
- `req`  out  8  pending calls; bit i drives `in<i>` (bit 0 → `inG`).
- `req_open`  out  1  debounced open request → `inopen`.
- `req_close`  out  1  debounced close request → `inclose`.
- `target`  out  3  next floor to serve.
- `target_valid`  out  1  high when at least one call is pending.
- `pending_cnt`  out  4  number of pending calls, 0..8.

## Operation
- **Input conditioning.** Each of the 10 raw inputs passes through a 2-flop synchroniser and then a debouncer.
  - The debounced level flips only after the synchronised value has differed from it for `DB_CYCLES` consecutive cycles.
  - Any agreeing cycle clears that input's counter.
- **Serve condition.** `served[i] = at_floor & door_open & (cur_floor == i)`.
- **Pending set/clear.**
  - A debounced rising edge of `btn[i]` sets `req[i]`, unless `served[i]` is high in the same cycle.
  - `served[i]` clears `req[i]`. Clear wins over set.
  - Holding a button keeps the call pending; releasing it does not clear the call.
  - A second press while pending has no effect.
- **Door requests.** `req_open` = debounced `btn_open`. `req_close` = debounced `btn_close & ~btn_open`; open wins.
- **Target selection.** Registered. Evaluated every cycle from the current `req` and `cur_floor`, with internal sweep flag `sweep_up`. Priority:
  1. `req[cur_floor]` set → `target = cur_floor`.
  2. Otherwise, a call exists in the sweep direction → nearest such floor (`sweep_up`: lowest floor > `cur_floor`; else highest floor < `cur_floor`).
  3. Otherwise, a call exists in the opposite direction → nearest such floor, and `sweep_up` toggles on the same edge.
  4. No calls → `target` and `sweep_up` hold; `target_valid` = 0.
- **Count.** `pending_cnt` = registered popcount of the next-state `req`.

## Timing
- **Reset.** All outputs 0; `sweep_up` = 1; synchronisers, debounce levels and counters 0. Asserting reset mid-operation drops all pending calls immediately, asynchronously.
- **Press latency.** Raw input first sampled high at edge E and held steady:
  - `req[i]` / `req_open` / `req_close` rise after edge E+`DB_CYCLES`+2.
  - `target` / `target_valid` update after edge E+`DB_CYCLES`+3.
  - `pending_cnt` updates with `req`.
- **Release latency.** Same `DB_CYCLES`+2 delay for `req_open` / `req_close` to fall.
- **Glitch rejection.** Pulses shorter than `DB_CYCLES` cycles at the synchroniser output produce no change.
- **Clear latency.** `served[i]` high at edge F → `req[i]` low after F; `target_valid` falls after F+1 if that was the last call.
- **Simultaneous set + clear** on the same floor → stays or becomes 0.
- **Simultaneous presses** on several floors in one cycle → all set in the same cycle; `pending_cnt` jumps by that number.
- **Floor ends.** At floor 7 with `sweep_up` = 1 and calls below → reverse via priority 3. Symmetric at G.

## Test plan
- **Reset/idle.** `rst` low, then high, no buttons → all outputs 0, `sweep_up` = 1 (first call above 0 is chosen upward).
- **Single call.** `cur_floor` = 0, `btn[3]` held 10 cycles (`DB_CYCLES` = 4) → `req` = 0x08 after E+6; `target` = 3, `target_valid` = 1 after E+7; `pending_cnt` = 1. Then `cur_floor` = 3, `at_floor` = 1, `door_open` = 1 → `req` = 0x00; `target_valid` falls next cycle.
- **Glitch.** 3-cycle pulse on `btn[5]` → `req` stays 0x00.
- **SCAN order.** `cur_floor` = 4, calls at 2, 6, 7, `sweep_up` = 1 → `target` = 6. After serving 6 (`cur_floor` = 6) → `target` = 7. After serving 7 → `target` = 2, `sweep_up` = 0.
- **Served-floor press.** `cur_floor` = 1, `at_floor` = 1, `door_open` = 1, press `btn[1]` → `req[1]` never sets. Same press with `door_open` = 0 → `req[1]` = 1 and `target` = 1.
- **Door priority and reset mid-run.** Both `btn_open` and `btn_close` held → `req_open` = 1, `req_close` = 0. Release `btn_open` → `req_close` = 1 after 6 cycles. Then, with 3 calls pending, pulse `rst` low → `req` = 0, `pending_cnt` = 0, `target_valid` = 0 immediately.
